counter_host_ctrl: RTL and testbench

Host-side controller that drives the 8-bit loadable counter's control interface: load enable, output enable and preload value. It reads the counter's output data back. On each accepted command it preloads the counter and lets it run for a programmed number of cycles. It then enables the counter output, captures the count and checks it against the arithmetically expected value. The block sits beside the counter in the same tile and replaces manual pin toggling on the load/output-enable inputs with a self-checking sequence.

---
 rtl/counter_host_ctrl.sv | 105 ++++++++++
 tb/tb_counter_host_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_host_ctrl.sv
// Host-side sequencer for an 8-bit loadable counter: preload, free-run N cycles,
// read back and compare against V+N+1, keeping a saturating mismatch tally.
module counter_host_ctrl #(
    parameter int WIDTH = 8,
    parameter int RUN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] cmd_load_val,
    input  logic [RUN_W-1:0] cmd_run_cycles,
    output logic             load_e,
    output logic             out_e,
    output logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cnt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             mismatch,
    output logic [7:0]       mismatch_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        READ,
        CAPT
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [RUN_W-1:0] r_run;
    logic [WIDTH-1:0] r_expected;
    logic             w_accept;
    logic             w_mismatch;

    assign w_accept   = (r_state == IDLE) && start;
    assign w_mismatch = (cnt_data != r_expected);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: if (start) w_state_nx = LOAD;
            LOAD: w_state_nx = (r_run == '0) ? READ : RUN;
            RUN:  if (r_run == RUN_W'(1)) w_state_nx = READ;
            READ: w_state_nx = CAPT;
            CAPT: w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // The reference is fixed at acceptance so later command inputs are don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_val   <= '0;
            r_run      <= '0;
            r_expected <= '0;
        end else if (w_accept) begin
            load_val   <= cmd_load_val;
            r_run      <= cmd_run_cycles;
            r_expected <= cmd_load_val + WIDTH'(cmd_run_cycles) + WIDTH'(1);
        end else if (r_state == RUN) begin
            r_run <= r_run - RUN_W'(1);
        end
    end

    // Strobes are decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_e <= 1'b0;
            out_e  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            load_e <= (w_state_nx == LOAD);
            out_e  <= (w_state_nx == READ) || (w_state_nx == CAPT);
            busy   <= (w_state_nx != IDLE);
            done   <= (r_state == CAPT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result       <= '0;
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
        end else if (r_state == CAPT) begin
            result   <= cnt_data;
            mismatch <= w_mismatch;
            if (w_mismatch && (mismatch_cnt != 8'hFF)) begin
                mismatch_cnt <= mismatch_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_counter_host_ctrl.sv
// Self-checking bench for counter_host_ctrl: an ideal (or stuck) counter model sits on
// the control interface and every transaction is compared against (V+N+1) mod 256.
module tb_counter_host_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] cmdLoadVal = 8'h00;
    logic [7:0] cmdRunCycles = 8'h00;
    logic       loadE;
    logic       outE;
    logic [7:0] loadVal;
    logic [7:0] cntData;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       mismatch;
    logic [7:0] mismatchCnt;

    logic [7:0] counterModel;
    bit         stuckFault = 1'b0;

    int         checks = 0;
    int         errors = 0;
    int         expMismatchCnt = 0;
    logic [7:0] lastResult = 8'h00;

    counter_host_ctrl #(.WIDTH(8), .RUN_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cmd_load_val   (cmdLoadVal),
        .cmd_run_cycles (cmdRunCycles),
        .load_e         (loadE),
        .out_e          (outE),
        .load_val       (loadVal),
        .cnt_data       (cntData),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .mismatch       (mismatch),
        .mismatch_cnt   (mismatchCnt)
    );

    always #5 clk = ~clk;

    // Counter being driven: loads on load_e, otherwise counts; output only valid under out_e.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) counterModel <= 8'h00;
        else if (loadE) counterModel <= loadVal;
        else counterModel <= counterModel + 8'd1;
    end

    assign cntData = stuckFault ? 8'h00 : (outE ? counterModel : 8'hA5);

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] refCount(input logic [7:0] v, input logic [7:0] n);
        int s;
        s = int'(v) + int'(n) + 1;
        return 8'(s % 256);
    endfunction

    // One full transaction; optionally re-pulses start mid-run with a different command.
    task automatic applyStimulus(input logic [7:0] v, input logic [7:0] n,
                                 input bit pulseInRun, input bit detailed);
        int         loadCnt = 0;
        int         outCnt = 0;
        int         doneCnt = 0;
        int         doneCyc = -1;
        logic       busyAtDone = 1'b1;
        logic [7:0] expResult;
        logic       expMis;
        expResult = stuckFault ? 8'h00 : refCount(v, n);
        expMis    = (expResult != refCount(v, n));
        @(negedge clk);
        start = 1'b1; cmdLoadVal = v; cmdRunCycles = n;
        @(posedge clk);
        for (int cyc = 1; cyc <= int'(n) + 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = 1'b0; cmdLoadVal = 8'($urandom); cmdRunCycles = 8'($urandom);
            end
            if (pulseInRun && cyc == 3) begin
                start = 1'b1; cmdLoadVal = v ^ 8'h5A; cmdRunCycles = n + 8'd1;
            end
            if (pulseInRun && cyc == 4) start = 1'b0;
            loadCnt += int'(loadE);
            outCnt  += int'(outE);
            if (done) begin
                doneCnt++;
                if (doneCyc < 0) begin doneCyc = cyc; busyAtDone = busy; end
            end
            if (detailed && cyc == int'(n) + 3) begin
                checkOutput("resultHeldBeforeDone", result, lastResult);
                checkOutput("busyDuringCapt", busy, 1'b1);
            end
        end
        if (expMis && expMismatchCnt < 255) expMismatchCnt++;
        checkOutput("doneLatency", doneCyc, int'(n) + 4);
        checkOutput("doneCount", doneCnt, 1);
        checkOutput("result", result, expResult);
        checkOutput("mismatch", mismatch, expMis);
        checkOutput("mismatchCnt", mismatchCnt, expMismatchCnt);
        if (detailed) begin
            checkOutput("loadEWidth", loadCnt, 1);
            checkOutput("outEWidth", outCnt, 2);
            checkOutput("busyAtDone", busyAtDone, 1'b0);
        end
        lastResult = expResult;
    endtask

    // start held high: second command must be accepted in the done cycle of the first.
    task automatic holdStartTest(input logic [7:0] v1, input logic [7:0] n1,
                                 input logic [7:0] v2, input logic [7:0] n2);
        int doneCyc = -1;
        @(negedge clk);
        start = 1'b1; cmdLoadVal = v1; cmdRunCycles = n1;
        @(posedge clk);
        for (int cyc = 1; cyc <= int'(n1) + 4; cyc++) @(negedge clk);
        checkOutput("holdFirstDone", done, 1'b1);
        checkOutput("holdFirstResult", result, refCount(v1, n1));
        cmdLoadVal = v2; cmdRunCycles = n2;
        @(posedge clk);
        @(negedge clk);
        checkOutput("holdSecondLoadE", loadE, 1'b1);
        checkOutput("holdSecondLoadVal", loadVal, v2);
        start = 1'b0;
        for (int cyc = 2; cyc <= int'(n2) + 10; cyc++) begin
            @(negedge clk);
            if (done && doneCyc < 0) doneCyc = cyc;
        end
        checkOutput("holdSecondLatency", doneCyc, int'(n2) + 4);
        checkOutput("holdSecondResult", result, refCount(v2, n2));
        lastResult = refCount(v2, n2);
    endtask

    // Asynchronous reset partway through a transaction.
    task automatic resetMidTxn(input logic [7:0] v, input logic [7:0] n, input int resetCyc);
        int doneCnt = 0;
        @(negedge clk);
        start = 1'b1; cmdLoadVal = v; cmdRunCycles = n;
        @(posedge clk);
        for (int cyc = 1; cyc <= resetCyc; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rstLoadE", loadE, 1'b0);
        checkOutput("rstOutE", outE, 1'b0);
        checkOutput("rstBusy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        expMismatchCnt = 0;
        lastResult = 8'h00;
        checkOutput("rstNoDone", doneCnt, 0);
        checkOutput("rstResult", result, 8'h00);
        checkOutput("rstMismatchCnt", mismatchCnt, 8'h00);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("resetLoadE", loadE, 1'b0);
        checkOutput("resetOutE", outE, 1'b0);
        checkOutput("resetBusy", busy, 1'b0);
        checkOutput("resetDone", done, 1'b0);
        checkOutput("resetResult", result, 8'h00);
        checkOutput("resetLoadVal", loadVal, 8'h00);
        checkOutput("resetMismatch", mismatch, 1'b0);
        checkOutput("resetMismatchCnt", mismatchCnt, 8'h00);
        rst_n = 1'b1;

        applyStimulus(8'h10, 8'd5, 1'b0, 1'b1);
        applyStimulus(8'hFE, 8'd3, 1'b0, 1'b1);
        applyStimulus(8'h7F, 8'd0, 1'b0, 1'b1);
        applyStimulus(8'h33, 8'd6, 1'b1, 1'b1);
        holdStartTest(8'h10, 8'd2, 8'hC8, 8'd7);

        stuckFault = 1'b1;
        applyStimulus(8'h20, 8'd4, 1'b0, 1'b1);
        for (int i = 1; i < 300; i++) applyStimulus(8'h20, 8'($urandom_range(3, 0)), 1'b0, 1'b0);
        checkOutput("mismatchCntSaturated", mismatchCnt, 8'd255);
        stuckFault = 1'b0;

        for (int i = 0; i < 20; i++)
            applyStimulus(8'($urandom), 8'($urandom_range(40, 0)), 1'b0, 1'b1);

        resetMidTxn(8'h40, 8'd10, 4);
        resetMidTxn(8'h40, 8'd10, 1);
        resetMidTxn(8'h40, 8'd10, 12);
        applyStimulus(8'h40, 8'd10, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
